// File: rtl/prbs_burst_sched.sv
// prbs_burst_sched: reseeds a PRBS9 generator and frames its decimated advance pulses into gapped bursts
module prbs_burst_sched #(
  parameter int OVERSAMPLE = 4,
  parameter int LEN_W = 16,
  parameter int NB_W = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [LEN_W-1:0] i_burst_len,
  input  logic [LEN_W-1:0] i_gap_len,
  input  logic [NB_W-1:0]  i_nbursts,
  output logic             o_prbs_reset,
  output logic             o_prbs_ctrl,
  output logic             o_bit_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_bit_cnt,
  output logic [NB_W-1:0]  o_burst_cnt
);
  localparam int PH_W = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, SEED, RUN, GAP, DONE} state_t;
  state_t state;
  logic [PH_W-1:0] phase;
  logic [LEN_W-1:0] burst_len, gap_len, gap_cnt, bit_nxt;
  logic [NB_W-1:0] nbursts, burst_nxt;
  logic burst_end, run_end;
  assign o_prbs_ctrl = (state == RUN) && (phase == PH_LAST) && !i_stop;
  assign o_prbs_reset = state == SEED;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign bit_nxt = o_bit_cnt + LEN_W'(1);
  assign burst_nxt = o_burst_cnt + NB_W'(1);
  assign burst_end = o_prbs_ctrl && (bit_nxt == burst_len);
  assign run_end = burst_end && (nbursts != '0) && (burst_nxt == nbursts);
  // sequencing of seed, decimated bursts, gaps and completion; stop overrides every active state
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= IDLE;
      phase <= '0;
      gap_cnt <= '0;
      burst_len <= '0;
      gap_len <= '0;
      nbursts <= '0;
      o_bit_cnt <= '0;
      o_burst_cnt <= '0;
      o_bit_valid <= 1'b0;
    end else begin
      o_bit_valid <= o_prbs_ctrl;
      if (state != IDLE && i_stop) state <= IDLE;
      else
        case (state)
          IDLE:
            if (i_start) begin
              burst_len <= i_burst_len;
              gap_len <= i_gap_len;
              nbursts <= i_nbursts;
              o_bit_cnt <= '0;
              o_burst_cnt <= '0;
              phase <= '0;
              gap_cnt <= '0;
              state <= SEED;
            end
          SEED: begin
            phase <= '0;
            state <= burst_len == '0 ? DONE : RUN;
          end
          RUN: begin
            phase <= phase == PH_LAST ? '0 : phase + PH_W'(1);
            if (burst_end) begin
              o_burst_cnt <= burst_nxt;
              o_bit_cnt <= run_end ? bit_nxt : '0;
              gap_cnt <= '0;
              state <= run_end ? DONE : (gap_len == '0 ? RUN : GAP);
            end else if (o_prbs_ctrl) o_bit_cnt <= bit_nxt;
          end
          GAP:
            if (gap_cnt == gap_len - LEN_W'(1)) begin
              phase <= '0;
              state <= RUN;
            end else gap_cnt <= gap_cnt + LEN_W'(1);
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_prbs_burst_sched.sv
// tb_prbs_burst_sched: three oversample variants checked every cycle against a timeline model
module tb_prbs_burst_sched;
  logic clk = 1'b0;
  logic rst, start, stop;
  logic [15:0] bl, gl;
  logic [7:0] nb;
  logic [2:0] pr, pc, bv, bs, dn;
  logic [2:0][15:0] bc;
  logic [2:0][7:0] uc;
  int total = 0, bad = 0, cyc = 0;
  bit chk = 1'b0;
  bit act[3];
  int a[3], ml[3], mg[3], mn[3];
  logic [15:0] hb[3];
  logic [7:0] hu[3];
  bit pv[3];
  int npulse[3], fp[3], lp[3], dat[3], nseed[3];

  for (genvar g = 0; g < 3; g++) begin : u
    prbs_burst_sched #(.OVERSAMPLE(g == 0 ? 1 : (g == 1 ? 2 : 4)), .LEN_W(16), .NB_W(8)) dut (
      .clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
      .i_burst_len(bl), .i_gap_len(gl), .i_nbursts(nb),
      .o_prbs_reset(pr[g]), .o_prbs_ctrl(pc[g]), .o_bit_valid(bv[g]), .o_busy(bs[g]),
      .o_done(dn[g]), .o_bit_cnt(bc[g]), .o_burst_cnt(uc[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ck(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", n, got, want, cyc);
    end
  endfunction

  // timeline model: after accept cycle a, SEED at a+1, bursts of L*os run cycles each followed by a gap
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int os, d, e, fin, p, b, r;
      bit eb, es, ec, ed;
      logic [15:0] ebc;
      logic [7:0] euc;
      os = i == 0 ? 1 : (i == 1 ? 2 : 4);
      eb = 0; es = 0; ec = 0; ed = 0;
      ebc = hb[i]; euc = hu[i];
      if (act[i]) begin
        d = cyc - a[i];
        eb = 1; ebc = 0; euc = 0;
        if (d == 1) es = 1;
        else if (ml[i] == 0) ed = 1;
        else begin
          e = d - 2;
          fin = mn[i] * ml[i] * os + (mn[i] - 1) * mg[i];
          if (mn[i] != 0 && e == fin) begin
            ed = 1; ebc = 16'(ml[i]); euc = 8'(mn[i]);
          end else begin
            p = ml[i] * os + mg[i];
            b = e / p;
            r = e % p;
            if (r < ml[i] * os) begin
              ec = (r % os) == os - 1;
              ebc = 16'(r / os);
              euc = 8'(b);
            end else euc = 8'(b + 1);
          end
        end
      end
      ec = ec && !stop;
      if (chk) begin
        ck($sformatf("busy%0d", i), int'(bs[i]), int'(eb));
        ck($sformatf("reseed%0d", i), int'(pr[i]), int'(es));
        ck($sformatf("ctrl%0d", i), int'(pc[i]), int'(ec));
        ck($sformatf("done%0d", i), int'(dn[i]), int'(ed));
        ck($sformatf("valid%0d", i), int'(bv[i]), int'(pv[i]));
        ck($sformatf("bitcnt%0d", i), int'(bc[i]), int'(ebc));
        ck($sformatf("burstcnt%0d", i), int'(uc[i]), int'(euc));
      end
      if (pc[i]) begin
        npulse[i]++;
        if (fp[i] < 0) fp[i] = cyc - a[i];
        lp[i] = cyc - a[i];
      end
      if (pr[i]) nseed[i]++;
      if (dn[i]) dat[i] = cyc - a[i];
      if (rst) begin
        act[i] = 0; hb[i] = 0; hu[i] = 0; pv[i] = 0;
      end else begin
        pv[i] = ec;
        if (act[i]) begin
          if (stop || ed) begin
            act[i] = 0; hb[i] = ebc; hu[i] = euc;
          end
        end else if (start) begin
          act[i] = 1; a[i] = cyc;
          ml[i] = int'(bl); mg[i] = int'(gl); mn[i] = int'(nb);
          npulse[i] = 0; fp[i] = -1; lp[i] = -1; dat[i] = -1; nseed[i] = 0;
        end
      end
    end
  end

  task automatic start_run(input int l, input int g, input int n);
    start = 1; bl = 16'(l); gl = 16'(g); nb = 8'(n);
    @(posedge clk); #1;
    start = 0; bl = 16'($urandom); gl = 16'($urandom); nb = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bs != 3'b000 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (bs != 3'b000) begin
      bad++; total++;
      $display("FAIL wait_idle timeout busy=%b", bs);
    end
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; bl = 0; gl = 0; nb = 0;
    repeat (2) @(posedge clk);
    #1 chk = 1; rst = 0;
    ck("rst_busy", int'(bs), 0);
    ck("rst_bitcnt", int'(bc[2]), 0);
    ck("rst_valid", int'(bv), 0);
    // single burst, os=4, L=8, N=1, gap=3
    start_run(8, 3, 1);
    wait_idle();
    ck("sb_pulses", npulse[2], 8);
    ck("sb_first", fp[2], 5);
    ck("sb_last", lp[2], 33);
    ck("sb_done", dat[2], 34);
    ck("sb_bitcnt", int'(bc[2]), 8);
    ck("sb_burstcnt", int'(uc[2]), 1);
    // multi burst, os=2, L=5, N=3, gap=4
    start_run(5, 4, 3);
    wait_idle();
    ck("mb_pulses", npulse[1], 15);
    ck("mb_seeds", nseed[1], 1);
    ck("mb_done", dat[1], 40);
    // zero-length burst
    start_run(0, 5, 2);
    wait_idle();
    ck("l0_pulses", npulse[2], 0);
    ck("l0_done", dat[2], 2);
    // back-to-back bursts, os=1
    start_run(3, 0, 2);
    wait_idle();
    ck("g0_pulses", npulse[0], 6);
    ck("g0_first", fp[0], 2);
    ck("g0_last", lp[0], 7);
    ck("g0_done", dat[0], 8);
    // continuous mode, stopped on a ctrl cycle after 300 bursts
    start_run(4, 0, 0);
    repeat (1201) @(posedge clk);
    #1;
    ck("cont_burstcnt", int'(uc[0]), 44);
    stop = 1;
    #1;
    ck("stop_ctrl", int'(pc[0]), 0);
    @(posedge clk); #1;
    stop = 0;
    ck("stop_idle", int'(bs), 0);
    ck("stop_nodone", dat[0], -1);
    ck("stop_hold", int'(uc[0]), 44);
    // reset mid-RUN, then a normal run
    start_run(10, 2, 1);
    repeat (20) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    ck("mid_rst_busy", int'(bs), 0);
    ck("mid_rst_bitcnt", int'(bc[2]), 0);
    ck("mid_rst_valid", int'(bv), 0);
    start_run(8, 3, 1);
    wait_idle();
    ck("post_rst_done", dat[2], 34);
    // start while busy must not disturb the run
    start_run(6, 2, 2);
    repeat (10) @(posedge clk);
    #1 start = 1; bl = 3; gl = 0; nb = 1;
    @(posedge clk); #1;
    start = 0;
    wait_idle();
    ck("busy_start_pulses", npulse[2], 12);
    ck("busy_start_done", dat[2], 52);
    ck("busy_start_bitcnt", int'(bc[2]), 6);
    ck("busy_start_burstcnt", int'(uc[2]), 2);
    // random traffic
    for (int k = 0; k < 4000; k++) begin
      start = ($urandom % 8) == 0;
      bl = 16'($urandom % 7);
      gl = 16'($urandom % 6);
      nb = 8'($urandom % 4);
      stop = ($urandom % 40) == 0;
      rst = ($urandom % 600) == 0;
      @(posedge clk); #1;
    end
    start = 0; stop = 1; rst = 0;
    @(posedge clk); #1;
    stop = 0;
    repeat (3) @(posedge clk);
    #1;
    ck("final_idle", int'(bs), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
